// File: rtl/mux4_rr_sched.sv
`default_nettype none
//============================================================================
// Module  : mux4_rr_sched
// Brief   : Round-robin owner of a 4:1 bit mux select, with registered y/y_vld.
//           Optional macro MUX_SCHED_HOLD_EN enables MAX_HOLD forced rotation.
// Revision: 1.0 - initial release
//============================================================================
module mux4_rr_sched #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] a,
    output logic [3:0] gnt,
    output logic [1:0] s,
    output logic       busy,
    output logic       y,
    output logic       y_vld
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    generate
        if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_check
            $error("mux4_rr_sched: MAX_HOLD out of range 1..255");
        end
    endgenerate

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [3:0] r_gnt;
    logic [1:0] r_s;
    logic       r_y;
    logic       r_y_vld;

    logic [3:0] w_cand;
    logic       w_found;
    logic [1:0] w_win;
    logic [1:0] w_idx;
    logic       w_owner_req;
    logic       w_rotate;
    logic       w_switch;

    // While granted, the owner is masked out so any winner is a true hand-over.
    // r_ptr equals the owner in GRANT, so one search from ptr+1 serves all cases.
    always_comb begin
        w_cand  = (r_state == ST_GRANT) ? (req & ~r_gnt) : req;
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_owner_req = |(req & r_gnt);

`ifdef MUX_SCHED_HOLD_EN
    localparam logic [7:0] c_hold_lim = 8'(MAX_HOLD - 1);

    logic [7:0] r_cnt;

    assign w_rotate = (r_state == ST_GRANT) && (r_cnt == c_hold_lim) && w_found;

    // Saturates at the limit when nobody else is waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (w_switch && w_found) begin
            r_cnt <= 8'd0;
        end else if (r_state == ST_GRANT && r_cnt != c_hold_lim) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`else
    assign w_rotate = 1'b0;
`endif

    assign w_switch = (r_state == ST_IDLE) || !w_owner_req || w_rotate;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd3;
            r_gnt   <= 4'b0000;
            r_s     <= 2'd0;
            r_y     <= 1'b0;
            r_y_vld <= 1'b0;
        end else begin
            r_y     <= (r_state == ST_GRANT) ? a[r_s] : 1'b0;
            r_y_vld <= (r_state == ST_GRANT);
            if (w_switch) begin
                if (w_found) begin
                    r_state <= ST_GRANT;
                    r_ptr   <= w_win;
                    r_s     <= w_win;
                    r_gnt   <= 4'b0001 << w_win;
                end else begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 4'b0000;
                end
            end
        end
    end

    assign gnt   = r_gnt;
    assign s     = r_s;
    assign busy  = (r_state == ST_GRANT);
    assign y     = r_y;
    assign y_vld = r_y_vld;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_sched.sv
`default_nettype none
// Bench for mux4_rr_sched: behavioural reference pushes expected outputs to a
// queue each cycle; every test task pops and compares after the clock edge.
module tb_mux4_rr_sched;

    localparam int MAX_HOLD = 4;
`ifdef MUX_SCHED_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] a;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       busy;
    logic       y;
    logic       y_vld;

    always #5 clk = ~clk;

    mux4_rr_sched #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .a    (a),
        .gnt  (gnt),
        .s    (s),
        .busy (busy),
        .y    (y),
        .y_vld(y_vld)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [8:0] exp_q[$];

    // reference state
    bit         m_busy;
    logic [1:0] m_s;
    logic [1:0] m_ptr;
    int         m_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next-edge expectation {gnt, s, busy, y, y_vld} from current inputs.
    task automatic model_step(output logic [8:0] e);
        logic       y_n, v_n, hit;
        logic [3:0] others;
        int         base, idx;
        y_n = m_busy ? a[m_s] : 1'b0;
        v_n = m_busy;
        if (rst) begin
            m_busy = 0; m_ptr = 2'd3; m_s = 2'd0; m_cnt = 0;
            y_n = 1'b0; v_n = 1'b0;
        end else begin
            others = m_busy ? (req & ~(4'b0001 << m_s)) : req;
            hit = 1'b0;
            idx = 0;
            base = int'(m_ptr);
            for (int k = 1; k <= 4; k++) begin
                if (!hit && others[(base + k) % 4]) begin
                    hit = 1'b1;
                    idx = (base + k) % 4;
                end
            end
            if (!m_busy || !req[m_s] || (HOLD_EN && m_cnt == MAX_HOLD - 1 && others != 0)) begin
                if (hit) begin
                    m_busy = 1; m_s = 2'(idx); m_ptr = 2'(idx); m_cnt = 0;
                end else begin
                    m_busy = 0;
                end
            end else if (m_cnt < MAX_HOLD - 1) begin
                m_cnt++;
            end
        end
        e = {(m_busy ? (4'b0001 << m_s) : 4'b0000), m_s, m_busy, y_n, v_n};
    endtask

    task automatic apply_reset();
        logic [8:0] e;
        rst = 1'b1;
        model_step(e);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] e, got;
        rst = 1'b1; req = 4'b1111; a = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            model_step(e); exp_q.push_back(e);
            tick();
            got = {gnt, s, busy, y, y_vld}; e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_bad++; $display("FAIL reset cyc%0d got=%b exp=%b", i, got, e); end
        end
        n_cmp++;
        if ({gnt, s, busy, y, y_vld} !== 9'b0) begin
            n_bad++; $display("FAIL reset_const got=%b exp=%b", {gnt, s, busy, y, y_vld}, 9'b0);
        end
        rst = 1'b0;
        model_step(e); exp_q.push_back(e);
        tick();
        got = {gnt, s, busy, y, y_vld}; e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL reset_first got=%b exp=%b", got, e); end
        n_cmp++;
        if (gnt !== 4'b0001 || s !== 2'd0) begin
            n_bad++; $display("FAIL reset_first_gnt got gnt=%b s=%0d exp gnt=0001 s=0", gnt, s);
        end
    endtask

    task automatic test_single();
        logic [8:0] e, got;
        logic [3:0] req_tab [4] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic [3:0] gnt_tab [4] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic       vld_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        apply_reset();
        a = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            req = req_tab[i];
            model_step(e); exp_q.push_back(e);
            tick();
            got = {gnt, s, busy, y, y_vld}; e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_bad++; $display("FAIL single cyc%0d got=%b exp=%b", i, got, e); end
            n_cmp++;
            if (gnt !== gnt_tab[i] || y_vld !== vld_tab[i]) begin
                n_bad++;
                $display("FAIL single_const cyc%0d got gnt=%b vld=%b exp gnt=%b vld=%b",
                         i, gnt, y_vld, gnt_tab[i], vld_tab[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [8:0] e, got;
        int seq [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            model_step(e); exp_q.push_back(e);
            tick();
            got = {gnt, s, busy, y, y_vld}; e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_bad++; $display("FAIL rr cyc%0d got=%b exp=%b", i, got, e); end
            n_cmp++;
            if (s !== 2'(seq[i]) || busy !== 1'b1) begin
                n_bad++; $display("FAIL rr_seq step%0d got s=%0d busy=%b exp s=%0d busy=1", i, s, busy, seq[i]);
            end
            req = ~(4'b0001 << m_s);
        end
    endtask

    task automatic test_hold_limit();
        logic [8:0] e, got;
        logic [1:0] exp_s;
        apply_reset();
        req = 4'b0011;
        for (int i = 0; i < 16; i++) begin
            model_step(e); exp_q.push_back(e);
            tick();
            got = {gnt, s, busy, y, y_vld}; e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_bad++; $display("FAIL hold cyc%0d got=%b exp=%b", i, got, e); end
            exp_s = HOLD_EN ? 2'((i / MAX_HOLD) % 2) : 2'd0;
            n_cmp++;
            if (s !== exp_s) begin
                n_bad++; $display("FAIL hold_owner cyc%0d got s=%0d exp s=%0d", i, s, exp_s);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_mid_reset();
        logic [8:0] e, got;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0, 1:    begin rst = 1'b0; req = 4'b0100; end
                2:       begin rst = 1'b1; req = 4'b1111; end
                default: begin rst = 1'b0; req = 4'b0110; end
            endcase
            model_step(e); exp_q.push_back(e);
            tick();
            got = {gnt, s, busy, y, y_vld}; e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_bad++; $display("FAIL midrst cyc%0d got=%b exp=%b", i, got, e); end
        end
        rst = 1'b0;
        n_cmp++;
        if (gnt !== 4'b0010 || s !== 2'd1 || y_vld !== 1'b0) begin
            n_bad++; $display("FAIL midrst_next got gnt=%b s=%0d vld=%b exp gnt=0010 s=1 vld=0", gnt, s, y_vld);
        end
    endtask

    task automatic test_datapath();
        logic [8:0] e, got;
        logic       prev_a3;
        apply_reset();
        req = 4'b1000; a = 4'b0000;
        model_step(e); exp_q.push_back(e);
        tick();
        got = {gnt, s, busy, y, y_vld}; e = exp_q.pop_front(); n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL data_grant got=%b exp=%b", got, e); end
        for (int i = 0; i < 10; i++) begin
            a = {~a[3], 3'($urandom)};
            prev_a3 = a[3];
            model_step(e); exp_q.push_back(e);
            tick();
            got = {gnt, s, busy, y, y_vld}; e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_bad++; $display("FAIL data cyc%0d got=%b exp=%b", i, got, e); end
            n_cmp++;
            if (y !== prev_a3 || y_vld !== 1'b1) begin
                n_bad++; $display("FAIL data_follow cyc%0d got y=%b vld=%b exp y=%b vld=1", i, y, y_vld, prev_a3);
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] e, got;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            req = 4'($urandom);
            a   = 4'($urandom);
            model_step(e); exp_q.push_back(e);
            tick();
            got = {gnt, s, busy, y, y_vld}; e = exp_q.pop_front(); n_cmp++;
            if (got !== e) begin n_bad++; $display("FAIL random cyc%0d got=%b exp=%b", i, got, e); end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; a = 4'b0000;
        m_busy = 0; m_s = 2'd0; m_ptr = 2'd3; m_cnt = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_hold_limit();
        test_mid_reset();
        test_datapath();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux4_rr_sched.md
# mux4_rr_sched

Round-robin scheduler that shares the 4-to-1 single-bit mux between four requesters. Each requester owns one mux data input `a[i]`. The block arbitrates the requests and drives the mux select `s` plus a one-hot grant. It also registers the mux output `y` with a valid flag, so a downstream consumer sees which requester's bit is on the line. It sits directly in front of the 4x1 mux datapath and is the only agent allowed to drive its select.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles for one owner while others wait. Legal range 1..255.

- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, 4: request per requester; bit i requests the mux for input `a[i]`.
- `a`, in, 4: mux data inputs; bit i is owned by requester i.
- `gnt`, out, 4: one-hot grant, registered; all-zero when idle.
- `s`, out, 2: mux select, registered; equals the index of the set `gnt` bit.
- `busy`, out, 1: high while any grant is active.
- `y`, out, 1: registered mux output `a[s]`; 0 when no grant.
- `y_vld`, out, 1: `y` carries granted data.

## Operation
- States:
  - IDLE: `gnt`=0, `busy`=0.
  - GRANT: exactly one `gnt` bit set, `busy`=1.
- Round-robin pointer `ptr` (2 bits) holds the last granted index. Search order is `ptr+1, ptr+2, ptr+3, ptr`, mod 4.
- IDLE:
  - If `req`≠0, grant the first requester in search order and go to GRANT.
  - Set `ptr` and `s` to that index and clear the hold counter `cnt`.
- GRANT, owner o, evaluated each edge:
  - **Release**: `req[o]`=0. Re-arbitrate among `req` with o excluded, search starting at o+1. If there is a winner, switch to it on the same edge (no idle bubble) and set `cnt`=0. Otherwise go to IDLE.
  - **Forced rotation**: `req[o]`=1, `cnt`=MAX_HOLD-1, and any other `req` bit is set. Switch to the next requester in search order from o+1; set `cnt`=0.
  - **Hold**: otherwise keep o and increment `cnt`. If `cnt` reaches MAX_HOLD-1 with no other requester waiting, it stays at MAX_HOLD-1.
- `ptr` updates on every new grant, so fairness is based on the last owner.
- Datapath, registered each edge:
  - With a grant this cycle: `y` <= `a[s]`, `y_vld` <= 1.
  - Otherwise: `y` <= 0, `y_vld` <= 0.
- `cnt` is 8 bits and is unsigned-compared against MAX_HOLD-1.
- `a` is sampled only through the registered `y` path; the block has no other data storage.

## Timing
- Reset values, when `rst`=1 at an edge:
  - state IDLE, `ptr`=3 (so requester 0 wins first), `cnt`=0.
  - `gnt`=0, `s`=0, `busy`=0, `y`=0, `y_vld`=0.
- Reset takes priority over any request or grant, including mid-grant. The grant drops on that edge, and `y_vld` is 0 on the following cycle.
- Request to grant latency:
  - `req` seen high at edge N in IDLE gives `gnt`/`s`/`busy` valid after edge N.
  - The first `y_vld`=1 follows edge N+1, holding `a[s]` as sampled at edge N+1.
- Hand-over latency:
  - On release or rotation, the new `gnt` appears after the same edge on which the old owner is dropped.
  - `y` switches source one cycle later.
- Simultaneous events:
  - Release and the hold limit at the same edge is treated as a release.
  - If all four request at once from reset, the grant order is 0,1,2,3,0...
- A requester that deasserts `req` while not granted is simply skipped; there is no latching of requests.
- `gnt` is never multi-hot. `s` is stable whenever `gnt`=0 and holds its last value.

## Configuration
- `MUX_SCHED_HOLD_EN`:
  - Defined: the forced-rotation rule and `cnt` are implemented; MAX_HOLD is enforced.
  - Undefined: an owner keeps the grant until it drops `req`; `cnt` logic is removed and MAX_HOLD is ignored. Release and arbitration are otherwise identical.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with `req`=4'b1111 -> `gnt`=0, `s`=0, `busy`=0, `y`=0, `y_vld`=0. After release, the first grant is `gnt`=4'b0001, `s`=0.
- **Single requester:** `req`=4'b0100, `a`=4'b0100 -> the edge after IDLE gives `gnt`=4'b0100, `s`=2. One cycle later `y`=1, `y_vld`=1. Dropping `req` gives `gnt`=0 on the next edge and `y_vld`=0 one cycle after.
- **Round robin:** `req`=4'b1111 held, with each requester dropping `req` after 1 cycle of grant and re-raising it next cycle -> `s` sequence 0,1,2,3,0 with no idle cycle between grants.
- **Hold limit** (macro defined, MAX_HOLD=4): `req`=4'b0011 held continuously -> owner 0 for 4 cycles, then owner 1 for 4 cycles, alternating. With the macro undefined, owner 0 is held indefinitely.
- **Mid-grant reset:** owner 2 granted, `rst` pulsed 1 cycle -> `gnt`=0 and `ptr`=3 after that edge. The next grant goes to the lowest-index requester.
- **Data path:** owner 3 granted with `a[3]` toggling each cycle -> `y` follows `a[3]` delayed by one cycle. Toggling `a[0]`..`a[2]` has no effect on `y`.
